// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM capture and write-back bus for the MEM/WB stage
interface mem_wb_stage_if #(
  parameter int W = 16
);
  // EX/MEM side
  logic         in_valid;
  logic [5:0]   in_op;
  logic [2:0]   in_regA;
  logic [2:0]   in_regB;
  logic [2:0]   in_regC;
  logic         in_CCR_write;
  logic [W-1:0] in_alu_result;
  logic [W-1:0] in_mem_data;
  logic [W-1:0] in_pc_plus1;
  logic         in_carry;
  logic         in_zero;
  logic         freeze;

  // Stage state, write-back port and architectural state
  logic [5:0]   mem_wb_op;
  logic [2:0]   mem_wb_regA;
  logic [2:0]   mem_wb_regB;
  logic [2:0]   mem_wb_regC;
  logic         mem_wb_CCR_write;
  logic [W-1:0] wb_data;
  logic         rf_we;
  logic [2:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic [1:0]   ccr;
  logic [15:0]  retired_count;

  modport master (
    output in_valid, in_op, in_regA, in_regB, in_regC, in_CCR_write,
           in_alu_result, in_mem_data, in_pc_plus1, in_carry, in_zero, freeze,
    input  mem_wb_op, mem_wb_regA, mem_wb_regB, mem_wb_regC, mem_wb_CCR_write,
           wb_data, rf_we, rf_waddr, rf_wdata, ccr, retired_count
  );

  modport slave (
    input  in_valid, in_op, in_regA, in_regB, in_regC, in_CCR_write,
           in_alu_result, in_mem_data, in_pc_plus1, in_carry, in_zero, freeze,
    output mem_wb_op, mem_wb_regA, mem_wb_regB, mem_wb_regC, mem_wb_CCR_write,
           wb_data, rf_we, rf_waddr, rf_wdata, ccr, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, write-back select, flags and retire counter
module mem_wb_stage #(
  parameter int         W         = 16,
  parameter logic [5:0] BUBBLE_OP = 6'b111111,
  parameter logic [5:0] OP_ADD    = 6'b000000,
  parameter logic [5:0] OP_ADC    = 6'b000010,
  parameter logic [5:0] OP_ADZ    = 6'b000001,
  parameter logic [5:0] OP_NDU    = 6'b001000,
  parameter logic [5:0] OP_NDC    = 6'b001010,
  parameter logic [5:0] OP_NDZ    = 6'b001001,
  parameter logic [3:0] OP_ADI    = 4'b0001,
  parameter logic [3:0] OP_LHI    = 4'b0011,
  parameter logic [3:0] OP_LW     = 4'b0100,
  parameter logic [3:0] OP_SW     = 4'b0101,
  parameter logic [3:0] OP_LM     = 4'b0110,
  parameter logic [3:0] OP_SM     = 4'b0111,
  parameter logic [3:0] OP_BEQ    = 4'b1100,
  parameter logic [3:0] OP_JAL    = 4'b1000,
  parameter logic [3:0] OP_JLR    = 4'b1001
) (
  input logic          clk,
  input logic          reset_n,
  mem_wb_stage_if.slave bus
);

  logic         valid_q;
  logic [5:0]   op_q;
  logic [2:0]   rega_q;
  logic [2:0]   regb_q;
  logic [2:0]   regc_q;
  logic         supp_q;
  logic [W-1:0] alu_q;
  logic [W-1:0] mem_q;
  logic [W-1:0] pc1_q;
  logic         carry_q;
  logic         zero_q;
  logic [1:0]   ccr_q;
  logic [15:0]  count_q;

  logic [3:0]   op_hi;
  logic         is_add, is_nd, is_r, is_adi, is_lhi, is_lw, is_lm, is_jal, is_jlr;
  logic         writes_rf, retire, commit;
  logic [2:0]   waddr;
  logic [W-1:0] wdata;

  assign op_hi  = op_q[5:2];
  assign is_add = (op_q == OP_ADD) || (op_q == OP_ADC) || (op_q == OP_ADZ);
  assign is_nd  = (op_q == OP_NDU) || (op_q == OP_NDC) || (op_q == OP_NDZ);
  assign is_r   = is_add || is_nd;
  assign is_adi = (op_hi == OP_ADI);
  assign is_lhi = (op_hi == OP_LHI);
  assign is_lw  = (op_hi == OP_LW);
  assign is_lm  = (op_hi == OP_LM);
  assign is_jal = (op_hi == OP_JAL);
  assign is_jlr = (op_hi == OP_JLR);

  // SW, SM, BEQ and unknown opcodes fall outside the writing classes
  assign writes_rf = is_r || is_adi || is_lhi || is_lw || is_lm || is_jal || is_jlr;
  assign retire    = valid_q && !bus.freeze;
  assign commit    = retire && !supp_q;

  // Destination register and write-back value by opcode class
  always_comb begin
    waddr = rega_q;
    if (is_r)
      waddr = regc_q;
    else if (is_adi)
      waddr = regb_q;
    wdata = alu_q;
    if (is_lw || is_lm)
      wdata = mem_q;
    else if (is_jal || is_jlr)
      wdata = pc1_q;
  end

  // Stage register: capture when not frozen, empty slots become bubbles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      op_q    <= BUBBLE_OP;
      rega_q  <= 3'd0;
      regb_q  <= 3'd0;
      regc_q  <= 3'd0;
      supp_q  <= 1'b1;
      alu_q   <= '0;
      mem_q   <= '0;
      pc1_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!bus.freeze) begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        op_q    <= bus.in_op;
        rega_q  <= bus.in_regA;
        regb_q  <= bus.in_regB;
        regc_q  <= bus.in_regC;
        supp_q  <= bus.in_CCR_write;
        alu_q   <= bus.in_alu_result;
        mem_q   <= bus.in_mem_data;
        pc1_q   <= bus.in_pc_plus1;
        carry_q <= bus.in_carry;
        zero_q  <= bus.in_zero;
      end else begin
        op_q    <= BUBBLE_OP;
        rega_q  <= 3'd0;
        regb_q  <= 3'd0;
        regc_q  <= 3'd0;
        supp_q  <= 1'b1;
        alu_q   <= '0;
        mem_q   <= '0;
        pc1_q   <= '0;
        carry_q <= 1'b0;
        zero_q  <= 1'b0;
      end
    end
  end

  // Condition codes update as the instruction in WB commits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ccr_q <= 2'b00;
    end else if (commit) begin
      if (is_add || is_adi)
        ccr_q <= {carry_q, zero_q};
      else if (is_nd)
        ccr_q[0] <= zero_q;
      else if (is_lw)
        ccr_q[0] <= (mem_q == '0);
    end
  end

  // Every real instruction leaving WB counts, suppressed or not; wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_q <= 16'd0;
    else if (retire)
      count_q <= count_q + 16'd1;
  end

  assign bus.mem_wb_op        = op_q;
  assign bus.mem_wb_regA      = rega_q;
  assign bus.mem_wb_regB      = regb_q;
  assign bus.mem_wb_regC      = regc_q;
  assign bus.mem_wb_CCR_write = supp_q;
  assign bus.wb_data          = wdata;
  assign bus.rf_we            = commit && writes_rf;
  assign bus.rf_waddr         = waddr;
  assign bus.rf_wdata         = wdata;
  assign bus.ccr              = ccr_q;
  assign bus.retired_count    = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  localparam int W = 16;
  localparam logic [5:0] BUB = 6'b111111;
  localparam logic [5:0] ADD = 6'b000000, ADC = 6'b000010, ADZ = 6'b000001;
  localparam logic [5:0] NDU = 6'b001000, NDC = 6'b001010, NDZ = 6'b001001;
  localparam logic [3:0] ADI4 = 4'b0001, LHI4 = 4'b0011, LW4 = 4'b0100, SW4 = 4'b0101;
  localparam logic [3:0] LM4 = 4'b0110, SM4 = 4'b0111, BEQ4 = 4'b1100, JAL4 = 4'b1000;
  localparam logic [3:0] JLR4 = 4'b1001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.W(W)) bus ();
  mem_wb_stage #(.W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit          valid;
    logic [5:0]  op;
    logic [2:0]  ra, rb, rc;
    bit          supp;
    logic [15:0] alu, mem, pc1;
    bit          c, z;
  } instr_t;

  typedef struct {
    instr_t      ins;
    bit          we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  ccr_after;
  } vec_t;

  instr_t      stg;
  logic [1:0]  m_ccr;
  logic [15:0] m_cnt;
  bit          cur_frz;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic instr_t mk(bit v, logic [5:0] op, logic [2:0] ra, logic [2:0] rb,
                                logic [2:0] rc, bit supp, logic [15:0] alu,
                                logic [15:0] mem, logic [15:0] pc1, bit c, bit z);
    instr_t i;
    i.valid = v; i.op = op; i.ra = ra; i.rb = rb; i.rc = rc; i.supp = supp;
    i.alu = alu; i.mem = mem; i.pc1 = pc1; i.c = c; i.z = z;
    return i;
  endfunction

  function automatic bit is_add(logic [5:0] op);
    return op inside {ADD, ADC, ADZ};
  endfunction
  function automatic bit is_nd(logic [5:0] op);
    return op inside {NDU, NDC, NDZ};
  endfunction
  function automatic bit writes(logic [5:0] op);
    logic [3:0] h;
    h = op[5:2];
    return is_add(op) || is_nd(op) || (h inside {ADI4, LHI4, LW4, LM4, JAL4, JLR4});
  endfunction
  function automatic logic [2:0] dest(instr_t i);
    if (is_add(i.op) || is_nd(i.op)) return i.rc;
    if (i.op[5:2] == ADI4) return i.rb;
    return i.ra;
  endfunction
  function automatic logic [15:0] wbval(instr_t i);
    if (i.op[5:2] inside {LW4, LM4}) return i.mem;
    if (i.op[5:2] inside {JAL4, JLR4}) return i.pc1;
    return i.alu;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(instr_t i, bit frz);
    bus.in_valid = i.valid; bus.in_op = i.op;
    bus.in_regA = i.ra; bus.in_regB = i.rb; bus.in_regC = i.rc;
    bus.in_CCR_write = i.supp; bus.in_alu_result = i.alu;
    bus.in_mem_data = i.mem; bus.in_pc_plus1 = i.pc1;
    bus.in_carry = i.c; bus.in_zero = i.z; bus.freeze = frz;
    cur_frz = frz;
  endtask

  task automatic model_reset();
    stg = mk(0, BUB, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    m_ccr = 2'b00;
    m_cnt = 16'd0;
  endtask

  task automatic model_check();
    bit ewe;
    ewe = stg.valid && writes(stg.op) && !stg.supp && !cur_frz;
    chk("op", bus.mem_wb_op, stg.valid ? stg.op : BUB);
    chk("supp", bus.mem_wb_CCR_write, stg.valid ? stg.supp : 1'b1);
    chk("regA", bus.mem_wb_regA, stg.valid ? stg.ra : 3'd0);
    chk("regB", bus.mem_wb_regB, stg.valid ? stg.rb : 3'd0);
    chk("regC", bus.mem_wb_regC, stg.valid ? stg.rc : 3'd0);
    chk("rf_we", bus.rf_we, ewe);
    if (stg.valid) begin
      chk("wb_data", bus.wb_data, wbval(stg));
      chk("rf_wdata", bus.rf_wdata, wbval(stg));
    end
    if (ewe) chk("rf_waddr", bus.rf_waddr, dest(stg));
    chk("ccr", bus.ccr, m_ccr);
    chk("count", bus.retired_count, m_cnt);
  endtask

  task automatic model_edge(instr_t nxt, bit frz);
    if (!frz) begin
      if (stg.valid) begin
        m_cnt = m_cnt + 16'd1;
        if (!stg.supp) begin
          if (is_add(stg.op) || stg.op[5:2] == ADI4) m_ccr = {stg.c, stg.z};
          else if (is_nd(stg.op)) m_ccr[0] = stg.z;
          else if (stg.op[5:2] == LW4) m_ccr[0] = (stg.mem == 16'd0);
        end
      end
      stg = nxt.valid ? nxt : mk(0, BUB, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic cycle(instr_t i, bit frz);
    drive(i, frz);
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge(i, frz);
    #1;
  endtask

  // Drive one cycle and also check the write port against fixed values
  task automatic cycle_exp(string name, instr_t i, bit frz, bit we, logic [2:0] wa, logic [15:0] wd);
    drive(i, frz);
    @(negedge clk);
    model_check();
    chk({name, " we"}, bus.rf_we, we);
    chk({name, " waddr"}, bus.rf_waddr, wa);
    chk({name, " wdata"}, bus.rf_wdata, wd);
    @(posedge clk);
    model_edge(i, frz);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] rl [6];
    logic [3:0] hl [9];
    logic [31:0] r;
    rl = '{ADD, ADC, ADZ, NDU, NDC, NDZ};
    hl = '{ADI4, LHI4, LW4, SW4, LM4, SM4, BEQ4, JAL4, JLR4};
    r = $urandom;
    if (r[0]) return rl[$urandom_range(0, 5)];
    return {hl[$urandom_range(0, 8)], r[2:1]};
  endfunction

  vec_t   tbl [15];
  instr_t bub, ins, nxt;
  instr_t lm [3];
  logic [15:0] cnt_before;

  initial begin
    bub = mk(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{mk(1, ADD, 1, 2, 3, 0, 16'h0000, 16'h9999, 16'h0011, 1, 1), 1, 3, 16'h0000, 2'b11};
    tbl[1]  = '{mk(1, ADC, 1, 2, 4, 1, 16'h1234, 16'h0000, 16'h0000, 0, 0), 0, 4, 16'h1234, 2'b11};
    tbl[2]  = '{mk(1, NDU, 0, 1, 2, 0, 16'h00F0, 16'h0000, 16'h0000, 0, 0), 1, 2, 16'h00F0, 2'b10};
    tbl[3]  = '{mk(1, {LW4, 2'b00}, 5, 3, 6, 0, 16'h0055, 16'h0000, 16'h0000, 0, 0), 1, 5, 16'h0000, 2'b11};
    tbl[4]  = '{mk(1, {JAL4, 2'b00}, 7, 1, 2, 0, 16'h1111, 16'h2222, 16'h0043, 0, 0), 1, 7, 16'h0043, 2'b11};
    tbl[5]  = '{mk(1, {ADI4, 2'b10}, 1, 2, 3, 0, 16'h0007, 16'h0000, 16'h0000, 0, 0), 1, 2, 16'h0007, 2'b00};
    tbl[6]  = '{mk(1, {LW4, 2'b01}, 6, 0, 1, 0, 16'h0000, 16'h0008, 16'h0000, 1, 1), 1, 6, 16'h0008, 2'b00};
    tbl[7]  = '{mk(1, {LHI4, 2'b11}, 4, 5, 6, 0, 16'hAB00, 16'h0001, 16'h0002, 1, 1), 1, 4, 16'hAB00, 2'b00};
    tbl[8]  = '{mk(1, {SW4, 2'b00}, 2, 3, 4, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1), 0, 2, 16'h0000, 2'b00};
    tbl[9]  = '{mk(1, {BEQ4, 2'b00}, 3, 4, 5, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1), 0, 3, 16'h0000, 2'b00};
    tbl[10] = '{mk(1, {JLR4, 2'b00}, 6, 0, 1, 0, 16'h0005, 16'h0009, 16'h0100, 0, 0), 1, 6, 16'h0100, 2'b00};
    tbl[11] = '{mk(1, ADZ, 0, 0, 1, 0, 16'h0005, 16'h0000, 16'h0000, 1, 0), 1, 1, 16'h0005, 2'b10};
    tbl[12] = '{mk(1, NDZ, 0, 0, 2, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1), 0, 2, 16'h0000, 2'b10};
    tbl[13] = '{mk(1, {LM4, 2'b00}, 3, 0, 1, 0, 16'h0001, 16'h0077, 16'h0000, 0, 0), 1, 3, 16'h0077, 2'b10};
    tbl[14] = '{mk(1, NDC, 0, 1, 5, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1), 1, 5, 16'h0000, 2'b11};

    // reset state
    drive(bub, 0);
    model_reset();
    #12;
    chk("rst op", bus.mem_wb_op, 6'h3F);
    chk("rst supp", bus.mem_wb_CCR_write, 1'b1);
    chk("rst we", bus.rf_we, 1'b0);
    chk("rst ccr", bus.ccr, 2'b00);
    chk("rst count", bus.retired_count, 16'd0);
    reset_n = 1'b1;
    @(posedge clk);
    model_edge(bub, 0);
    #1;

    // directed table: instruction, then its WB cycle, then flags afterwards
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].ins, 0);
      drive(bub, 0);
      @(negedge clk);
      model_check();
      chk($sformatf("tbl%0d we", i), bus.rf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d waddr", i), bus.rf_waddr, tbl[i].wa);
        chk($sformatf("tbl%0d wdata", i), bus.rf_wdata, tbl[i].wd);
      end
      @(posedge clk);
      model_edge(bub, 0);
      #1;
      chk($sformatf("tbl%0d ccr", i), bus.ccr, tbl[i].ccr_after);
      chk($sformatf("tbl%0d count", i), bus.retired_count, 16'(i + 1));
    end

    // freeze held two cycles in WB, released on the same edge as a new capture
    ins = mk(1, {ADI4, 2'b00}, 5, 2, 6, 0, 16'h0ABC, 16'h0000, 16'h0000, 0, 1);
    nxt = mk(1, {LHI4, 2'b00}, 4, 1, 1, 0, 16'h5500, 16'h0000, 16'h0000, 0, 0);
    cycle(ins, 0);
    cnt_before = m_cnt;
    cycle_exp("frz1", nxt, 1, 0, 3'd2, 16'h0ABC);
    cycle_exp("frz2", nxt, 1, 0, 3'd2, 16'h0ABC);
    chk("frz count held", bus.retired_count, cnt_before);
    cycle_exp("frz rel", nxt, 0, 1, 3'd2, 16'h0ABC);
    chk("frz count +1", bus.retired_count, cnt_before + 16'd1);
    chk("frz ccr", bus.ccr, 2'b01);
    cycle_exp("after rel", bub, 0, 1, 3'd4, 16'h5500);
    chk("after rel count", bus.retired_count, cnt_before + 16'd2);

    // randomized stream against the model
    for (int n = 0; n < 3000; n++) begin
      ins = mk($urandom_range(0, 4) != 0, rand_op(), 3'($urandom), 3'($urandom), 3'($urandom),
               $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               16'($urandom), 1'($urandom), 1'($urandom));
      cycle(ins, $urandom_range(0, 4) == 0);
    end

    // asynchronous reset mid-stream with an instruction in WB
    cycle(mk(1, ADD, 1, 1, 2, 0, 16'h0000, 0, 0, 1, 1), 0);
    drive(mk(1, {LM4, 2'b00}, 3, 0, 0, 0, 0, 16'h00AA, 0, 0, 0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async op", bus.mem_wb_op, 6'h3F);
    chk("async we", bus.rf_we, 1'b0);
    chk("async ccr", bus.ccr, 2'b00);
    chk("async count", bus.retired_count, 16'd0);
    model_reset();
    drive(bub, 0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    model_edge(bub, 0);
    #1;

    // counter wrap
    ins = mk(1, {SW4, 2'b00}, 1, 2, 3, 0, 16'h0000, 0, 0, 0, 0);
    while (m_cnt != 16'hFFFF) cycle(ins, 0);
    chk("pre-wrap count", bus.retired_count, 16'hFFFF);
    cycle(bub, 0);
    chk("wrap count", bus.retired_count, 16'h0000);

    // three back-to-back LM beats
    lm[0] = mk(1, {LM4, 2'b00}, 1, 0, 0, 0, 16'h0000, 16'h1001, 0, 0, 0);
    lm[1] = mk(1, {LM4, 2'b00}, 4, 0, 0, 0, 16'h0000, 16'h1004, 0, 0, 0);
    lm[2] = mk(1, {LM4, 2'b00}, 6, 0, 0, 0, 16'h0000, 16'h1006, 0, 0, 0);
    cycle(lm[0], 0);
    cycle_exp("lm0", lm[1], 0, 1, 3'd1, 16'h1001);
    cycle_exp("lm1", lm[2], 0, 1, 3'd4, 16'h1004);
    cycle_exp("lm2", bub, 0, 1, 3'd6, 16'h1006);
    chk("lm count", bus.retired_count, 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter W, default 16: datapath width.
REQ-002 SHALL have parameter BUBBLE_OP, default 6'b111111: opcode driven for an empty stage; it matches no ISA opcode.
REQ-003 SHALL use the team's opcode parameters, matched as follows: ADD/NDU/ADC/ADZ/NDC/NDZ on the full 6-bit field; ADI/LHI/LW/SW/LM/SM/BEQ/JAL/JLR on op[5:2].
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  EX/MEM slot holds a real instruction.
REQ-007 in_op  in  6  EX/MEM opcode.
REQ-008 in_regA, in_regB, in_regC  in  3 each  EX/MEM register fields.
REQ-009 in_CCR_write  in  1  suppress flag: 1 = conditional op not committed (no RF/CCR write); 0 = commit.
REQ-010 in_alu_result  in  W  ALU result; for LHI it is the upper-immediate value.
REQ-011 in_mem_data  in  W  load data (LW, each LM beat).
REQ-012 in_pc_plus1  in  W  link value for JAL/JLR.
REQ-013 in_carry, in_zero  in  1 each  ALU flags.
REQ-014 freeze  in  1  hold stage; block all writes.
REQ-015 mem_wb_op  out  6  registered opcode, consumed by forwarding.
REQ-016 mem_wb_regA, mem_wb_regB, mem_wb_regC  out  3 each  registered fields.
REQ-017 mem_wb_CCR_write  out  1  registered suppress flag.
REQ-018 wb_data  out  W  selected write-back value, also the forwarding data bus.
REQ-019 rf_we  out  1  register-file write enable.
REQ-020 rf_waddr  out  3  register-file write address.
REQ-021 rf_wdata  out  W  register-file write data; equals wb_data.
REQ-022 ccr  out  2  architectural flags: [1] = C, [0] = Z.
REQ-023 retired_count  out  16  count of retired instructions.

Function
REQ-024 SHALL capture in_* into the mem_wb_* registers on each rising edge when freeze=0.
REQ-025 When in_valid=0 at capture, SHALL load mem_wb_op=BUBBLE_OP, mem_wb_CCR_write=1, fields=0.
REQ-026 SHALL hold all stage registers, ccr and retired_count while freeze=1.
REQ-027 SHALL select rf_waddr by opcode class:
  - R-type: regC
  - ADI: regB
  - LHI/LW/LM/JAL/JLR: regA
REQ-028 SHALL select wb_data by opcode class:
  - LW/LM: registered mem_data
  - JAL/JLR: registered pc_plus1
  - all others: registered alu_result
REQ-029 rf_we SHALL be combinational = stage valid AND writing class (R-type, ADI, LHI, LW, LM, JAL, JLR) AND mem_wb_CCR_write=0 AND freeze=0.
REQ-030 SW/SM/BEQ and bubbles SHALL never assert rf_we.
REQ-031 rf_we, rf_waddr and rf_wdata SHALL be valid in the WB cycle, i.e. one cycle after capture; the register file commits on the following edge.
REQ-032 On the edge ending a WB cycle with freeze=0, valid=1 and mem_wb_CCR_write=0, SHALL update ccr:
  - ADD/ADC/ADZ/ADI: C and Z from the registered flags
  - NDU/NDC/NDZ: Z only
  - LW: Z = (mem_data==0), C unchanged
  - all others: unchanged
REQ-033 Each LM beat SHALL be one independent write: the beat's destination in regA, data in mem_data.
REQ-034 Consecutive LM beats SHALL retire one per cycle with no internal state.
REQ-035 retired_count SHALL increment by 1 at the end of each valid, non-frozen WB cycle, including suppressed instructions.
REQ-036 retired_count SHALL wrap from 0xFFFF to 0x0000.
REQ-037 A freeze release SHALL produce exactly one write and one count for the held instruction.
REQ-038 When freeze deasserts on the same edge as a new capture, the held instruction SHALL retire and the new one SHALL be captured behind it, with no loss or duplication.

Reset
REQ-039 reset_n=0 SHALL immediately set:
  - mem_wb_op=BUBBLE_OP, mem_wb_CCR_write=1, fields=0
  - stored data=0
  - ccr=2'b00, retired_count=0
REQ-040 During reset, rf_we SHALL be 0.
REQ-041 A reset mid-LM or mid-freeze SHALL discard the in-flight instruction with no write.

Verification
REQ-042 Reset: assert reset_n=0 mid-stream -> mem_wb_op=6'h3F, rf_we=0, ccr=00, retired_count=0, asynchronously.
REQ-043 ADD r3: in_op=000000, regC=3, alu=0x0000, carry=1, CCR_write=0 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x0000; following edge ccr=11.
REQ-044 ADC suppressed: CCR_write=1, alu=0x1234 -> rf_we=0, ccr unchanged, retired_count +1.
REQ-045 LW r5 with mem_data=0x0000, then JAL r7 with pc_plus1=0x0043:
  - LW: waddr=5, wdata=0x0000, Z=1, C unchanged
  - JAL: waddr=7, wdata=0x0043
REQ-046 ADI r2 with freeze held 2 cycles during WB -> rf_we=0 and outputs stable both cycles; then exactly one write to r2 and count +1.
REQ-047 Counter wrap and LM: preload 0xFFFF, retire one instruction -> retired_count=0x0000; a 3-beat LM to r1, r4, r6 -> three consecutive writes.
